// File: rtl/game_ctrl_if.sv
// game_ctrl_if: the bundle between the playfield and the game supervisor.
// The playfield side (master) drives the collision flag, the frog X position
// and the start button. The supervisor side (slave) returns game state, lives,
// score, best score, the respawn pulse and the freeze level.
//
// There is no valid/ready pairing on this bundle: every input is a level that
// is sampled on each rising clock edge, and every output is a register that
// is valid in every cycle.
interface game_ctrl_if #(
    parameter int SCORE_W = 8
);
    logic               die;
    logic [9:0]         FrogX;
    logic               btnStart;
    logic [1:0]         state;
    logic [1:0]         lives;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] hi_score;
    logic               respawn;
    logic               freeze;

    modport master (
        output die, FrogX, btnStart,
        input  state, lives, score, hi_score, respawn, freeze
    );

    modport slave (
        input  die, FrogX, btnStart,
        output state, lives, score, hi_score, respawn, freeze
    );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: game-level supervisor for the frog/crocodile playfield.
// Sequences IDLE -> PLAY -> HIT/OVER, counts lives and crossings, pulses
// respawn for one cycle on each (re)entry to play and after each goal, and
// holds freeze high whenever the game is not in PLAY.
//
// Optional feature macro: GAME_CTRL_HISCORE_EN
//   defined     - hi_score latches the best score seen on entry to OVER,
//                 cleared only by rst.
//   not defined - hi_score is tied to 0; no register or comparator exists.
//
// The FSM state is visible directly on bus.state (0 IDLE, 1 PLAY, 2 HIT,
// 3 OVER), so checkers can bind to it without extra debug ports.
module game_ctrl #(
    parameter int LIVES        = 3,
    parameter int GOAL_X       = 600,
    parameter int HIT_CYCLES   = 25_000_000,
    parameter int GUARD_CYCLES = 1024,
    parameter int SCORE_W      = 8
) (
    input  logic          clk,
    input  logic          rst,
    game_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam int TIMER_W = (HIT_CYCLES > 1) ? $clog2(HIT_CYCLES) : 1;
    localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);

    localparam logic [1:0]         LIVES_INIT = 2'(LIVES);
    localparam logic [9:0]         GOAL       = 10'(GOAL_X);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(HIT_CYCLES - 1);
    localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(GUARD_CYCLES);

    state_t             state_q;
    logic [1:0]         lives_q;
    logic [SCORE_W-1:0] score_q;
    logic               respawn_q;
    logic               freeze_q;
    logic [GUARD_W-1:0] guard_q;
    logic [TIMER_W-1:0] timer_q;
    logic               die_q;
    logic               start_q;

    logic die_edge;
    logic start_edge;
    logic goal;

    // Rising-edge detection against the registered copies; a level held high
    // is never seen twice.
    assign die_edge   = bus.die & ~die_q;
    assign start_edge = bus.btnStart & ~start_q;
    assign goal       = (bus.FrogX >= GOAL);

`ifdef GAME_CTRL_HISCORE_EN
    logic [SCORE_W-1:0] hi_q;
`endif

    // Single-block FSM: state, counters and all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lives_q   <= LIVES_INIT;
            score_q   <= '0;
            respawn_q <= 1'b0;
            freeze_q  <= 1'b1;
            guard_q   <= '0;
            timer_q   <= '0;
            die_q     <= 1'b0;
            start_q   <= 1'b0;
`ifdef GAME_CTRL_HISCORE_EN
            hi_q      <= '0;
`endif
        end else begin
            die_q     <= bus.die;
            start_q   <= bus.btnStart;
            respawn_q <= 1'b0;

            case (state_q)
                IDLE, OVER: begin
                    // New game: refill lives, clear score, open a guard window.
                    if (start_edge) begin
                        state_q   <= PLAY;
                        freeze_q  <= 1'b0;
                        lives_q   <= LIVES_INIT;
                        score_q   <= '0;
                        guard_q   <= GUARD_INIT;
                        respawn_q <= 1'b1;
                    end
                end

                PLAY: begin
                    if (guard_q != '0) begin
                        // Guard window: die edges and goals are dropped, not queued.
                        guard_q <= guard_q - GUARD_W'(1);
                    end else if (die_edge) begin
                        // Die has priority over a simultaneous goal.
                        lives_q <= lives_q - 2'd1;
                        if (lives_q == 2'd1) begin
                            state_q  <= OVER;
                            freeze_q <= 1'b1;
`ifdef GAME_CTRL_HISCORE_EN
                            if (score_q > hi_q) begin
                                hi_q <= score_q;
                            end
`endif
                        end else begin
                            state_q  <= HIT;
                            freeze_q <= 1'b1;
                            timer_q  <= '0;
                        end
                    end else if (goal) begin
                        if (score_q != '1) begin
                            score_q <= score_q + SCORE_W'(1);
                        end
                        respawn_q <= 1'b1;
                        guard_q   <= GUARD_INIT;
                    end
                end

                HIT: begin
                    // Timer runs 0..HIT_CYCLES-1, so HIT lasts HIT_CYCLES cycles.
                    if (timer_q == TIMER_LAST) begin
                        state_q   <= PLAY;
                        freeze_q  <= 1'b0;
                        respawn_q <= 1'b1;
                        guard_q   <= GUARD_INIT;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.state   = state_q;
    assign bus.lives   = lives_q;
    assign bus.score   = score_q;
    assign bus.respawn = respawn_q;
    assign bus.freeze  = freeze_q;

`ifdef GAME_CTRL_HISCORE_EN
    assign bus.hi_score = hi_q;
`else
    assign bus.hi_score = '0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: randomized bench for game_ctrl. A driver applies one input
// vector per cycle and pushes the outputs a reference model predicts for the
// following edge; a monitor pops one expectation after every rising edge and
// compares it against the DUT outputs.
module tb_game_ctrl;

    localparam int LIVES        = 3;
    localparam int GOAL_X       = 600;
    localparam int HIT_CYCLES   = 4;
    localparam int GUARD_CYCLES = 3;
    localparam int SCORE_W      = 8;
    localparam int EW           = 6 + 2 * SCORE_W;
    localparam int SCORE_MAX    = (1 << SCORE_W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    game_ctrl_if #(.SCORE_W(SCORE_W)) bus();

    game_ctrl #(
        .LIVES        (LIVES),
        .GOAL_X       (GOAL_X),
        .HIT_CYCLES   (HIT_CYCLES),
        .GUARD_CYCLES (GUARD_CYCLES),
        .SCORE_W      (SCORE_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: game phase plus "cycles remaining" counters.
    int m_phase;      // 0 idle, 1 play, 2 hit, 3 over
    int m_lives;
    int m_score;
    int m_hi;
    int m_guard_left; // play cycles still ignoring die/goal
    int m_hit_left;   // hit cycles still to spend
    bit m_respawn;
    bit m_die_prev;
    bit m_start_prev;

    function automatic logic [EW-1:0] pack_exp();
        logic [1:0]         st;
        logic [1:0]         lv;
        logic [SCORE_W-1:0] sc;
        logic [SCORE_W-1:0] hs;
        st = 2'(m_phase);
        lv = 2'(m_lives);
        sc = SCORE_W'(m_score);
        hs = SCORE_W'(m_hi);
        return {st, lv, sc, hs, m_respawn, (m_phase != 1)};
    endfunction

    task automatic model_reset();
        m_phase      = 0;
        m_lives      = LIVES;
        m_score      = 0;
        m_hi         = 0;
        m_guard_left = 0;
        m_hit_left   = 0;
        m_respawn    = 1'b0;
        m_die_prev   = 1'b0;
        m_start_prev = 1'b0;
    endtask

    task automatic enter_play();
        m_phase      = 1;
        m_respawn    = 1'b1;
        m_guard_left = GUARD_CYCLES;
    endtask

    // Advance the model by one clock edge for the given inputs.
    task automatic model_step(input bit r, input bit d, input int fx, input bit s);
        bit die_edge;
        bit start_edge;
        if (r) begin
            model_reset();
        end else begin
            die_edge   = d && !m_die_prev;
            start_edge = s && !m_start_prev;
            m_respawn  = 1'b0;
            if (m_phase == 0 || m_phase == 3) begin
                if (start_edge) begin
                    m_lives = LIVES;
                    m_score = 0;
                    enter_play();
                end
            end else if (m_phase == 1) begin
                if (m_guard_left > 0) begin
                    m_guard_left--;
                end else if (die_edge) begin
                    m_lives--;
                    if (m_lives == 0) begin
                        m_phase = 3;
`ifdef GAME_CTRL_HISCORE_EN
                        if (m_score > m_hi) m_hi = m_score;
`endif
                    end else begin
                        m_phase    = 2;
                        m_hit_left = HIT_CYCLES;
                    end
                end else if (fx >= GOAL_X) begin
                    m_score = (m_score < SCORE_MAX) ? m_score + 1 : SCORE_MAX;
                    enter_play();
                end
            end else begin
                m_hit_left--;
                if (m_hit_left == 0) enter_play();
            end
            m_die_prev   = d;
            m_start_prev = s;
        end
        exp_q.push_back(pack_exp());
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input bit r, input bit d, input logic [9:0] fx, input bit s);
        @(negedge clk);
        rst          = r;
        bus.die      = d;
        bus.FrogX    = fx;
        bus.btnStart = s;
        model_step(r, d, int'(fx), s);
    endtask

    logic [9:0] fx_tab[6] = '{10'd0, 10'd300, 10'd599, 10'd600, 10'd601, 10'd1023};

    task automatic random_phase(input int cycles, input int rst_odds);
        bit d;
        bit s;
        logic [9:0] fx;
        d  = 1'b0;
        s  = 1'b0;
        fx = 10'd0;
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(0, 5) == 0) d = ~d;
            if ($urandom_range(0, 7) == 0) s = ~s;
            if ($urandom_range(0, 3) == 0) fx = fx_tab[$urandom_range(0, 5)];
            drive_cycle(($urandom_range(1, rst_odds) == 1), d, fx, s);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [EW-1:0] exp_v;
        logic [EW-1:0] act_v;
        #1;
        cyc++;
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {bus.state, bus.lives, bus.score, bus.hi_score, bus.respawn, bus.freeze};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL outputs cycle %0d: actual st=%0d lv=%0d sc=%0d hi=%0d rs=%0b fz=%0b required st=%0d lv=%0d sc=%0d hi=%0d rs=%0b fz=%0b",
                         cyc,
                         act_v[EW-1 -: 2], act_v[EW-3 -: 2], act_v[2*SCORE_W+1 -: SCORE_W],
                         act_v[SCORE_W+1 -: SCORE_W], act_v[1], act_v[0],
                         exp_v[EW-1 -: 2], exp_v[EW-3 -: 2], exp_v[2*SCORE_W+1 -: SCORE_W],
                         exp_v[SCORE_W+1 -: SCORE_W], exp_v[1], exp_v[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.die      = 1'b0;
        bus.FrogX    = 10'd0;
        bus.btnStart = 1'b0;
        model_reset();

        // Reset, then a start press held for a few cycles.
        repeat (3) drive_cycle(1'b1, 1'b0, 10'd0, 1'b0);
        drive_cycle(1'b0, 1'b0, 10'd0, 1'b1);
        drive_cycle(1'b0, 1'b0, 10'd0, 1'b1);
        drive_cycle(1'b0, 1'b0, 10'd0, 1'b0);

        // Goal boundary: 599 then 600 held past guard expiry.
        repeat (4) drive_cycle(1'b0, 1'b0, 10'd599, 1'b0);
        repeat (6) drive_cycle(1'b0, 1'b0, 10'd600, 1'b0);

        // Simultaneous die edge and goal after guard expiry; then die held
        // high straight through the HIT interval and the next guard window.
        drive_cycle(1'b0, 1'b0, 10'd100, 1'b0);
        repeat (3) drive_cycle(1'b0, 1'b0, 10'd100, 1'b0);
        drive_cycle(1'b0, 1'b1, 10'd600, 1'b0);
        repeat (10) drive_cycle(1'b0, 1'b1, 10'd100, 1'b0);
        drive_cycle(1'b0, 1'b0, 10'd100, 1'b0);

        // Long random play with occasional reset.
        random_phase(3000, 400);

        // Score saturation: a fresh game with the frog parked on the goal.
        drive_cycle(1'b1, 1'b0, 10'd0, 1'b0);
        drive_cycle(1'b0, 1'b0, 10'd0, 1'b1);
        repeat (1100) drive_cycle(1'b0, 1'b0, 10'd650, 1'b0);
        // Then lose all lives to reach OVER with a full score.
        for (int k = 0; k < 3; k++) begin
            repeat (4) drive_cycle(1'b0, 1'b0, 10'd0, 1'b0);
            drive_cycle(1'b0, 1'b1, 10'd0, 1'b0);
            repeat (HIT_CYCLES + 1) drive_cycle(1'b0, 1'b0, 10'd0, 1'b0);
        end

        // More random play without reset, then reset mid-game.
        random_phase(800, 100000);
        drive_cycle(1'b1, 1'b0, 10'd0, 1'b0);
        drive_cycle(1'b0, 1'b0, 10'd0, 1'b0);

        // Drain: the last expectation is popped one edge after its push.
        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: actual %0d expectations left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Game-level supervisor that sits directly downstream of the frog/crocodile playfield. It consumes the collision flag from the death checker and the frog's X position. It tracks lives and score, and sequences the game through idle, play, hit and game-over states. It drives a one-cycle `respawn` pulse back to the frog position register and a `freeze` level that halts frog and crocodile motion.

## Interface
Parameters:
- `LIVES`, 3: lives loaded at reset and on every new game (1..3).
- `GOAL_X`, 600: frog X at or beyond which a crossing is scored.
- `HIT_CYCLES`, 25_000_000: cycles spent in HIT, 0.5 s at 50 MHz (≥2).
- `GUARD_CYCLES`, 1024: post-respawn window during which `die` and the goal are ignored (≥1).
- `SCORE_W`, 8: score width.

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset. Synchronous, active-high.
- `die` in 1: collision level from the death checker.
- `FrogX` in 10: current frog X position.
- `btnStart` in 1: debounced start button, level.
- `state` out 2: 0 IDLE, 1 PLAY, 2 HIT, 3 OVER.
- `lives` out 2: remaining lives.
- `score` out SCORE_W: crossings this game.
- `hi_score` out SCORE_W: best score (see Configuration).
- `respawn` out 1: one-cycle pulse; frog returns to its start position.
- `freeze` out 1: high when `state` ≠ PLAY.

## Operation
- All outputs are registered.
- Reset values: `state`=IDLE, `lives`=LIVES, `score`=0, `hi_score`=0, `respawn`=0, `freeze`=1. Internal guard=0, timer=0, `die_q`=0, `start_q`=0.
- Edge detection:
  - `die_q` and `start_q` are registered copies of the inputs.
  - die_edge = `die` & ~`die_q`.
  - start_edge = `btnStart` & ~`start_q`.
- IDLE:
  - start_edge → PLAY next cycle, with `respawn`=1, `lives`=LIVES, `score`=0, guard loaded with GUARD_CYCLES.
- PLAY:
  - Guard counter decrements to 0. While guard≠0, die_edge and goal are ignored; the edge is consumed, not deferred.
  - With guard=0 and die_edge: next cycle `lives`−1.
    - If the result is 0 → OVER.
    - Otherwise → HIT, timer cleared to 0.
  - With guard=0, no die_edge, and `FrogX` ≥ GOAL_X: next cycle `score`+1, `respawn`=1, guard reloaded, state stays PLAY.
  - `score` saturates at 2^SCORE_W−1.
  - Die edge and goal in the same cycle: die wins, no score.
- HIT:
  - Timer increments each cycle.
  - In the cycle timer==HIT_CYCLES−1, the next cycle is PLAY with `respawn`=1 and guard reloaded.
  - HIT therefore lasts exactly HIT_CYCLES cycles.
  - `die` and `btnStart` are ignored.
- OVER:
  - start_edge → same action as from IDLE.
  - `lives` stays 0.
- `btnStart` is ignored in PLAY and HIT.
- `freeze` = (next state ≠ PLAY). It is registered alongside `state`.

## Timing
- Input sampled at edge n → state, lives, score and respawn update at edge n+1 (latency 1).
- `respawn` is high for exactly one cycle, in the same cycle as the first PLAY cycle after a transition into PLAY. It is also high for one cycle after a goal.
- Guard is reloaded in the `respawn` cycle. Die and goal are evaluated again starting GUARD_CYCLES cycles later.
- A `die` level held high across the end of the guard is not an edge and is not counted.
- `rst` asserted in any state, including mid-HIT, returns all outputs to reset values at the next edge. A pending `respawn` is dropped.
- Counter widths: timer is $clog2(HIT_CYCLES) bits; guard is $clog2(GUARD_CYCLES+1) bits. Neither wraps; both hold at their terminal value.

## Configuration
- `GAME_CTRL_HISCORE_EN` defined:
  - `hi_score` updates to `score` on every entry to OVER where `score` > `hi_score`.
  - `hi_score` is cleared only by `rst`, not by start.
- Not defined: `hi_score` is constant 0 and no comparator or register is built.

## Test plan
Use LIVES=3, GOAL_X=600, HIT_CYCLES=4, GUARD_CYCLES=3, SCORE_W=8.
- Reset then start pulse:
  - `state`=1, `respawn` high for 1 cycle, `lives`=3, `score`=0, `freeze`=0.
- Goal crossing: FrogX=600 held after guard expiry.
  - `score`=1 and `respawn` pulse one cycle later.
  - FrogX=599 → no change.
- Die edge after guard:
  - Next cycle `state`=2, `lives`=2, `freeze`=1.
  - Exactly 4 cycles later `state`=1 with `respawn`=1.
- Three die edges across the game:
  - `lives`=0, `state`=3.
  - Start edge → `lives`=3, `score`=0, `state`=1.
- Simultaneous die edge and FrogX=600 → `state`=2, `score` unchanged. A die edge within 3 cycles of a respawn is ignored.
- With `GAME_CTRL_HISCORE_EN`: score 5, game over → `hi_score`=5. Next game score 2, over → `hi_score`=5. `rst` → 0.
